// File: rtl/cr16_pkg.sv
// Types and default widths shared by the register-file readback logic and the datapath.
package cr16_pkg;

   localparam int unsigned CR16_DATA_WIDTH = 16;
   localparam int unsigned CR16_SEL_WIDTH  = 4;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      CAPTURE,
      PRESENT,
      DONE
   } readback_state_t;

endpackage

// File: rtl/fibonacci_reference_gen.sv
// Fibonacci reference sequence (1, 1, 2, 3, ...) with wrap-around addition.
module fibonacci_reference_gen
   import cr16_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CR16_DATA_WIDTH
) (
   input  logic                  I_CLK,
   input  logic                  I_RESET,
   input  logic                  I_INIT,
   input  logic                  I_ADVANCE,
   output logic [DATA_WIDTH-1:0] O_EXPECTED
);

   logic [DATA_WIDTH-1:0] ref_a_q;
   logic [DATA_WIDTH-1:0] ref_b_q;

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         ref_a_q <= '0;
         ref_b_q <= '0;
      end else if (I_INIT) begin
         ref_a_q <= DATA_WIDTH'(1);
         ref_b_q <= DATA_WIDTH'(1);
      end else if (I_ADVANCE) begin
         ref_a_q <= ref_b_q;
         ref_b_q <= ref_a_q + ref_b_q;
      end
   end

   assign O_EXPECTED = ref_a_q;

endmodule

// File: rtl/datapath_readback.sv
// Scans datapath registers FIRST_REG..LAST_REG through read port A, streams each word over
// valid/ready and flags the first word that differs from the Fibonacci reference.
module datapath_readback
   import cr16_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CR16_DATA_WIDTH,
   parameter int unsigned SEL_WIDTH  = CR16_SEL_WIDTH,
   parameter int unsigned FIRST_REG  = 0,
   parameter int unsigned LAST_REG   = 7
) (
   input  logic                  I_CLK,
   input  logic                  I_RESET,
   input  logic                  I_START,
   input  logic                  I_READY,
   input  logic [DATA_WIDTH-1:0] I_REG_DATA,
   output logic [SEL_WIDTH-1:0]  O_REG_A_SELECT,
   output logic [DATA_WIDTH-1:0] O_DATA,
   output logic [SEL_WIDTH-1:0]  O_INDEX,
   output logic                  O_VALID,
   output logic                  O_BUSY,
   output logic                  O_DONE,
   output logic                  O_MISMATCH,
   output logic [SEL_WIDTH-1:0]  O_MISMATCH_INDEX
);

   if (!(FIRST_REG <= LAST_REG && LAST_REG < (1 << SEL_WIDTH))) begin : g_bad_range
      $error("datapath_readback: need FIRST_REG <= LAST_REG < 2**SEL_WIDTH");
   end

   localparam logic [SEL_WIDTH-1:0] FIRST_SEL = SEL_WIDTH'(FIRST_REG);
   localparam logic [SEL_WIDTH-1:0] LAST_SEL  = SEL_WIDTH'(LAST_REG);

   readback_state_t       state_q, state_d;
   logic [SEL_WIDTH-1:0]  index_q, index_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SEL_WIDTH-1:0]  out_index_q, out_index_d;
   logic                  valid_q, valid_d;
   logic                  mism_q, mism_d;
   logic [SEL_WIDTH-1:0]  mism_index_q, mism_index_d;
   logic                  ref_init;
   logic                  ref_advance;
   logic [DATA_WIDTH-1:0] expected;

   fibonacci_reference_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ref (
      .I_CLK      (I_CLK),
      .I_RESET    (I_RESET),
      .I_INIT     (ref_init),
      .I_ADVANCE  (ref_advance),
      .O_EXPECTED (expected)
   );

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state_q      <= IDLE;
         index_q      <= '0;
         data_q       <= '0;
         out_index_q  <= '0;
         valid_q      <= 1'b0;
         mism_q       <= 1'b0;
         mism_index_q <= '0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         data_q       <= data_d;
         out_index_q  <= out_index_d;
         valid_q      <= valid_d;
         mism_q       <= mism_d;
         mism_index_q <= mism_index_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      data_d       = data_q;
      out_index_d  = out_index_q;
      valid_d      = valid_q;
      mism_d       = mism_q;
      mism_index_d = mism_index_q;
      ref_init     = 1'b0;
      ref_advance  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (I_START) begin
               index_d      = FIRST_SEL;
               mism_d       = 1'b0;
               mism_index_d = '0;
               ref_init     = 1'b1;
               state_d      = SELECT;
            end
         end
         // Read mux settles for one cycle before the data is sampled.
         SELECT: state_d = CAPTURE;
         CAPTURE: begin
            data_d      = I_REG_DATA;
            out_index_d = index_q;
            valid_d     = 1'b1;
            if (I_REG_DATA != expected && !mism_q) begin
               mism_d       = 1'b1;
               mism_index_d = index_q;
            end
            state_d = PRESENT;
         end
         PRESENT: begin
            if (I_READY) begin
               valid_d = 1'b0;
               if (index_q == LAST_SEL) begin
                  state_d = DONE;
               end else begin
                  index_d     = index_q + 1'b1;
                  ref_advance = 1'b1;
                  state_d     = SELECT;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The index register doubles as the registered port-A select.
   assign O_REG_A_SELECT   = index_q;
   assign O_DATA           = data_q;
   assign O_INDEX          = out_index_q;
   assign O_VALID          = valid_q;
   assign O_BUSY           = (state_q != IDLE);
   assign O_DONE           = (state_q == DONE);
   assign O_MISMATCH       = mism_q;
   assign O_MISMATCH_INDEX = mism_index_q;

endmodule

// File: tb/tb_datapath_readback.sv
// Directed bench: default scan, mismatch, back-pressure, reset/start abuse, 8-bit wrap, one word.
module tb_datapath_readback;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Default instance: 16-bit data, registers 0..7.
   logic        start, ready;
   logic [15:0] rf [16];
   logic [15:0] reg_data, data;
   logic [3:0]  sel, index, mism_index;
   logic        valid, busy, done, mism;
   assign reg_data = rf[sel];

   datapath_readback u_dut (
      .I_CLK            (clk),
      .I_RESET          (rst),
      .I_START          (start),
      .I_READY          (ready),
      .I_REG_DATA       (reg_data),
      .O_REG_A_SELECT   (sel),
      .O_DATA           (data),
      .O_INDEX          (index),
      .O_VALID          (valid),
      .O_BUSY           (busy),
      .O_DONE           (done),
      .O_MISMATCH       (mism),
      .O_MISMATCH_INDEX (mism_index)
   );

   // 8-bit instance scanning all 16 registers.
   logic       start8;
   logic [7:0] rf8 [16];
   logic [7:0] reg_data8, data8;
   logic [3:0] sel8, index8, mism_index8;
   logic       valid8, busy8, done8, mism8;
   assign reg_data8 = rf8[sel8];

   datapath_readback #(
      .DATA_WIDTH (8),
      .SEL_WIDTH  (4),
      .FIRST_REG  (0),
      .LAST_REG   (15)
   ) u_dut8 (
      .I_CLK            (clk),
      .I_RESET          (rst),
      .I_START          (start8),
      .I_READY          (1'b1),
      .I_REG_DATA       (reg_data8),
      .O_REG_A_SELECT   (sel8),
      .O_DATA           (data8),
      .O_INDEX          (index8),
      .O_VALID          (valid8),
      .O_BUSY           (busy8),
      .O_DONE           (done8),
      .O_MISMATCH       (mism8),
      .O_MISMATCH_INDEX (mism_index8)
   );

   // Single-register instance: FIRST_REG = LAST_REG = 3.
   logic        start1;
   logic [15:0] rf1 [16];
   logic [15:0] reg_data1, data1;
   logic [3:0]  sel1, index1, mism_index1;
   logic        valid1, busy1, done1, mism1;
   assign reg_data1 = rf1[sel1];

   datapath_readback #(
      .DATA_WIDTH (16),
      .SEL_WIDTH  (4),
      .FIRST_REG  (3),
      .LAST_REG   (3)
   ) u_dut1 (
      .I_CLK            (clk),
      .I_RESET          (rst),
      .I_START          (start1),
      .I_READY          (1'b1),
      .I_REG_DATA       (reg_data1),
      .O_REG_A_SELECT   (sel1),
      .O_DATA           (data1),
      .O_INDEX          (index1),
      .O_VALID          (valid1),
      .O_BUSY           (busy1),
      .O_DONE           (done1),
      .O_MISMATCH       (mism1),
      .O_MISMATCH_INDEX (mism_index1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_fib();
      rf[0] = 16'd1;  rf[1] = 16'd1;  rf[2] = 16'd2;  rf[3] = 16'd3;
      rf[4] = 16'd5;  rf[5] = 16'd8;  rf[6] = 16'd13; rf[7] = 16'd21;
      for (int i = 8; i < 16; i++) rf[i] = 16'hdead;
   endtask

   // Full 8-word scan on u_dut with ready held high; bad_first < 0 means no mismatch expected.
   task automatic run_full(input string tag, input int bad_first);
      int ndone;
      ndone = 0;
      start = 1'b1;
      ready = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (done) ndone++;
         if (c >= 2 && c <= 23 && (c - 2) % 3 == 0) begin
            int k;
            k = (c - 2) / 3;
            check({tag, " valid"}, 32'(valid), 32'd1);
            check({tag, " data"}, 32'(data), 32'(rf[k]));
            check({tag, " index"}, 32'(index), 32'(k));
            check({tag, " select"}, 32'(sel), 32'(k));
            if (bad_first >= 0 && k >= bad_first) begin
               check({tag, " mismatch"}, 32'(mism), 32'd1);
               check({tag, " mismatch_index"}, 32'(mism_index), 32'(bad_first));
            end else begin
               check({tag, " mismatch"}, 32'(mism), 32'd0);
            end
         end else if (c == 3 || c == 4) begin
            check({tag, " valid_gap"}, 32'(valid), 32'd0);
         end
         if (c == 24) check({tag, " done_at_24"}, 32'(done), 32'd1);
      end
      check({tag, " done_count"}, 32'(ndone), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      check({tag, " mismatch_end"}, 32'(mism), (bad_first >= 0) ? 32'd1 : 32'd0);
      check({tag, " mismatch_index_end"}, 32'(mism_index),
            (bad_first >= 0) ? 32'(bad_first) : 32'd0);
   endtask

   initial begin
      bit seen;
      start  = 1'b0;
      ready  = 1'b1;
      start8 = 1'b0;
      start1 = 1'b0;
      load_fib();
      rf8[0] = 8'd1;
      rf8[1] = 8'd1;
      for (int i = 2; i < 16; i++) rf8[i] = rf8[i-1] + rf8[i-2];
      for (int i = 0; i < 16; i++) rf1[i] = 16'hbeef;
      rf1[3] = 16'h0001;

      // Reset state.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset valid", 32'(valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset data", 32'(data), 32'd0);
      check("reset select", 32'(sel), 32'd0);
      check("reset index", 32'(index), 32'd0);
      check("reset mismatch", 32'(mism), 32'd0);
      check("reset mismatch_index", 32'(mism_index), 32'd0);
      check("reset busy8", 32'(busy8), 32'd0);
      check("reset select1", 32'(sel1), 32'd0);

      // Clean scan of r0..r7.
      run_full("scan_clean", -1);

      // Corrupted r5/r6: first mismatch latched at index 5 and held.
      rf[5] = 16'h0009;
      rf[6] = 16'h0000;
      run_full("scan_bad", 5);
      tick();
      check("idle mismatch hold", 32'(mism), 32'd1);
      check("idle mismatch_index hold", 32'(mism_index), 32'd5);

      // Back-pressure on index 2; new start clears mismatch.
      load_fib();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart clears mismatch", 32'(mism), 32'd0);
      check("restart busy", 32'(busy), 32'd1);
      for (int c = 1; c <= 8; c++) tick();
      check("bp index2 data", 32'(data), 32'h0002);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp hold valid", 32'(valid), 32'd1);
         check("bp hold data", 32'(data), 32'h0002);
         check("bp hold index", 32'(index), 32'd2);
         check("bp hold select", 32'(sel), 32'd2);
      end
      ready = 1'b1;
      tick();
      check("bp release valid", 32'(valid), 32'd0);
      check("bp release select", 32'(sel), 32'd3);
      tick();
      tick();
      check("bp next valid", 32'(valid), 32'd1);
      check("bp next index", 32'(index), 32'd3);
      check("bp next data", 32'(data), 32'h0003);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("bp done seen", 32'(seen), 32'd1);
      tick();

      // Start pulsed mid-scan is ignored; reset in PRESENT clears everything.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("midstart valid", 32'(valid), 32'd1);
      check("midstart index", 32'(index), 32'd1);
      check("midstart select", 32'(sel), 32'd1);
      for (int c = 6; c <= 14; c++) tick();
      check("pre-reset index", 32'(index), 32'd4);
      ready = 1'b0;
      tick();
      check("pre-reset hold valid", 32'(valid), 32'd1);
      check("pre-reset hold select", 32'(sel), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ready = 1'b1;
      check("rst valid", 32'(valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst data", 32'(data), 32'd0);
      check("rst index", 32'(index), 32'd0);
      check("rst select", 32'(sel), 32'd0);
      check("rst done", 32'(done), 32'd0);

      // 8-bit wrap: 377 -> 0x79, 610 -> 0x62, 987 -> 0xDB.
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 49; c++) begin
         tick();
         if (c == 2 + 3 * 13) check("w8 index13 data", 32'(data8), 32'h79);
         if (c == 2 + 3 * 14) check("w8 index14 data", 32'(data8), 32'h62);
         if (c == 2 + 3 * 15) begin
            check("w8 index15 data", 32'(data8), 32'hdb);
            check("w8 index15 index", 32'(index8), 32'd15);
         end
         if (c == 48) check("w8 done", 32'(done8), 32'd1);
      end
      check("w8 mismatch", 32'(mism8), 32'd0);
      check("w8 busy end", 32'(busy8), 32'd0);

      // Single-word scan of r3.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("single select", 32'(sel1), 32'd3);
      tick();
      tick();
      check("single valid", 32'(valid1), 32'd1);
      check("single index", 32'(index1), 32'd3);
      check("single data", 32'(data1), 32'h0001);
      tick();
      check("single done", 32'(done1), 32'd1);
      check("single mismatch", 32'(mism1), 32'd0);
      tick();
      check("single busy end", 32'(busy1), 32'd0);
      check("single done end", 32'(done1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
